// File: rtl/serial_arith_pkg.sv
// Shared types and defaults for the bit-serial arithmetic cells.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package serial_arith_pkg;

  // Default operand and result width of the serial datapaths.
  localparam int DEFAULT_W = 8;

  // Control FSM states of the serial subtractor.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage : serial_arith_pkg

// File: rtl/serial_subtractor_half_sub.sv
// Half-subtractor cell: single-bit x - y giving difference and borrow.
// Latency: purely combinational.
// Backpressure: none.
module half_sub (
  input  logic x,
  input  logic y,
  output logic d,
  output logic b
);

  // The difference bit is the XOR; a borrow occurs only for 0 - 1.
  assign d = x ^ y;
  assign b = ~x & y;

endmodule : half_sub

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, diff = (a - b) mod 2^W, processed LSB first.
// Latency: done pulses W cycles after the edge that accepts start.
// Backpressure: start is only honoured in IDLE or DONE; it is ignored while busy.
import serial_arith_pkg::*;

module serial_subtractor #(
  parameter int W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         borrow
);

  // Counter wide enough to hold 0..W.
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

  state_t          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_diff;
  logic            r_bq;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic            r_done;
  logic            r_borrow;

  logic            w_x;
  logic            w_y;
  logic            w_t;
  logic            w_b1;
  logic            w_d;
  logic            w_b2;
  logic            w_bout;
  logic            w_last;
  logic [W-1:0]    w_diff_shift;

  // Current operand bits come from the LSBs of the shift registers.
  assign w_x = r_a[0];
  assign w_y = r_b[0];

  // First stage subtracts the operand bits.
  half_sub u_hs_op (
    .x (w_x),
    .y (w_y),
    .d (w_t),
    .b (w_b1)
  );

  // Second stage subtracts the incoming borrow from the partial difference.
  half_sub u_hs_bin (
    .x (w_t),
    .y (r_bq),
    .d (w_d),
    .b (w_b2)
  );

  // The two stages can never both borrow, so OR merges them.
  assign w_bout = w_b1 | w_b2;

  // The final bit-step is the one taken while the counter sits at W-1.
  assign w_last = (r_cnt == LAST_CNT);

  // New difference bits enter at the MSB so the LSB ends up at bit 0 after W steps.
  if (W == 1) begin : g_diff_w1
    assign w_diff_shift = w_d;
  end else begin : g_diff_wn
    assign w_diff_shift = {w_d, r_diff[W-1:1]};
  end

  // Control FSM plus datapath registers; all outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_diff   <= '0;
      r_bq     <= 1'b0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_borrow <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state  <= ST_SHIFT;
            r_a      <= a;
            r_b      <= b;
            r_bq     <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_busy   <= 1'b1;
          end
        end

        ST_SHIFT: begin
          r_a    <= r_a >> 1;
          r_b    <= r_b >> 1;
          r_diff <= w_diff_shift;
          r_bq   <= w_bout;
          r_cnt  <= r_cnt + CW'(1);
          if (w_last) begin
            r_state  <= ST_DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_borrow <= w_bout;
          end
        end

        ST_DONE: begin
          // A start here chains straight into the next operation.
          r_done <= 1'b0;
          if (start) begin
            r_state  <= ST_SHIFT;
            r_a      <= a;
            r_b      <= b;
            r_bq     <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_busy   <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign diff   = r_diff;
  assign borrow = r_borrow;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: W=8 main instance plus a W=1 instance.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Every comparison is an immediate assertion that counts its own failures.
module tb_serial_subtractor;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       borrow;

  logic       start1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       busy1;
  logic       done1;
  logic [0:0] diff1;
  logic       borrow1;

  int checks;
  int errors;
  int n;

  serial_subtractor #(.W(8)) u_dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
  );

  serial_subtractor #(.W(1)) u_dut1 (
    .clk    (clk),
    .rst    (rst),
    .start  (start1),
    .a      (a1),
    .b      (b1),
    .busy   (busy1),
    .done   (done1),
    .diff   (diff1),
    .borrow (borrow1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Count falling edges on which busy is high; bounded so a stuck FSM cannot hang.
  task automatic count_busy(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  // One full operation from IDLE, checking latency, result and the single-cycle done.
  task automatic run_op(input string tag, input logic [7:0] aa, input logic [7:0] bb,
                        input logic [7:0] exp_d, input logic exp_bo);
    int c;
    a = aa; b = bb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    count_busy(c);
    check({tag, "_busy_cycles"}, c, 8);
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_diff"}, diff, exp_d);
    check({tag, "_borrow"}, borrow, exp_bo);
    @(negedge clk);
    check({tag, "_done_drop"}, done, 1'b0);
    check({tag, "_diff_hold"}, diff, exp_d);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    start = 1'b0; a = '0; b = '0;
    start1 = 1'b0; a1 = '0; b1 = '0;

    // Reset state
    #2;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_diff", diff, 8'h00);
    check("rst_borrow", borrow, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic arithmetic patterns
    run_op("t5a_23", 8'h5A, 8'h23, 8'h37, 1'b0);
    run_op("t00_01", 8'h00, 8'h01, 8'hFF, 1'b1);
    run_op("tff_ff", 8'hFF, 8'hFF, 8'h00, 1'b0);
    run_op("t80_7f", 8'h80, 8'h7F, 8'h01, 1'b0);

    // Start pulsed again in the third SHIFT cycle must be ignored
    a = 8'h10; b = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a = 8'hAA; b = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ign_busy", busy, 1'b1);
    count_busy(n);
    check("ign_busy_cycles", n, 5);
    check("ign_done", done, 1'b1);
    check("ign_diff", diff, 8'h0F);
    check("ign_borrow", borrow, 1'b0);
    @(negedge clk);
    check("ign_idle", busy, 1'b0);

    // Back-to-back: start held in DONE with new operands
    a = 8'h20; b = 8'h10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    count_busy(n);
    check("b2b_first_cycles", n, 8);
    check("b2b_first_done", done, 1'b1);
    check("b2b_first_diff", diff, 8'h10);
    check("b2b_first_borrow", borrow, 1'b0);
    a = 8'h03; b = 8'h05; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_rebusy", busy, 1'b1);
    check("b2b_done_drop", done, 1'b0);
    check("b2b_diff_clr", diff, 8'h00);
    count_busy(n);
    check("b2b_second_cycles", n, 8);
    check("b2b_second_done", done, 1'b1);
    check("b2b_second_diff", diff, 8'hFE);
    check("b2b_second_borrow", borrow, 1'b1);
    @(negedge clk);
    check("b2b_second_drop", done, 1'b0);

    // Asynchronous reset during the fourth SHIFT cycle
    a = 8'hFF; b = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("mid_busy", busy, 1'b1);
    check("mid_diff_partial", diff, 8'hE0);
    rst = 1'b1;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_diff", diff, 8'h00);
    check("arst_borrow", borrow, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    run_op("post_rst", 8'h09, 8'h04, 8'h05, 1'b0);

    // W=1 instance: one SHIFT cycle, 0 - 1 wraps with borrow
    a1 = 1'b0; b1 = 1'b1; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check("w1_busy", busy1, 1'b1);
    @(negedge clk);
    check("w1_busy_drop", busy1, 1'b0);
    check("w1_done", done1, 1'b1);
    check("w1_diff", diff1, 1'b1);
    check("w1_borrow", borrow1, 1'b1);
    @(negedge clk);
    check("w1_done_drop", done1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_serial_subtractor
